// File: rtl/twiddle_sequencer_fft_pkg.sv
// Shared constants for the SDF-stage twiddle sequencer: sample width, default geometry,
// twiddle address codes, the pipeline flag bundle and a compile-time log2 helper.
package fft_pkg;

  localparam int FFT_INTEGER_SIZE = 6;
  localparam int FFT_FRACT_SIZE   = 12;
  localparam int DATA_WIDTH       = FFT_INTEGER_SIZE + FFT_FRACT_SIZE;
  localparam int FFT_NFFT         = 64;
  localparam int FFT_SEG          = 8;

  localparam logic [5:0] TW_W0 = 6'd0;
  localparam logic [5:0] TW_W1 = 6'd1;
  localparam logic [5:0] TW_W2 = 6'd2;
  localparam logic [5:0] TW_W3 = 6'd3;

  typedef struct packed {
    logic valid;
    logic sof;
    logic last;
  } flags_t;

  // Smallest r with 2**r >= value; only ever fed powers of two here.
  function automatic int LOG2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/twiddle_sequencer_fft_delay_unit.sv
// delay_unit: one-cycle register with async active-low clear; models the
// multiplier's product register for the flag bundle.
module delay_unit #(
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
    end else begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/twiddle_sequencer_fft.sv
// twiddle_sequencer_fft: frame position counter, W8 twiddle address and flag pipeline
// in front of the constant multiplier. Build macro FRAME_CHECK_EN adds sticky frame_err_o.
module twiddle_sequencer_fft
  import fft_pkg::*;
#(
  parameter int INTEGER_SIZE = FFT_INTEGER_SIZE,
  parameter int FRACT_SIZE   = FFT_FRACT_SIZE,
  parameter int NFFT         = FFT_NFFT,
  parameter int SEG          = FFT_SEG
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               in_valid_i,
  input  logic                               in_sof_i,
  input  logic [INTEGER_SIZE+FRACT_SIZE-1:0] in_r_i,
  input  logic [INTEGER_SIZE+FRACT_SIZE-1:0] in_i_i,
  output logic [5:0]                         mult_addr_o,
  output logic [INTEGER_SIZE+FRACT_SIZE-1:0] mult_r_o,
  output logic [INTEGER_SIZE+FRACT_SIZE-1:0] mult_i_o,
  output logic                               out_valid_o,
  output logic                               out_sof_o,
`ifdef FRAME_CHECK_EN
  output logic                               frame_err_o,
`endif
  output logic                               out_last_o
);

  localparam int DW    = INTEGER_SIZE + FRACT_SIZE;
  localparam int CNT_W = LOG2(NFFT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NFFT - 1);

  // Only the last quarter-segment group of each 4*SEG period gets a nontrivial twiddle.
  function automatic logic [5:0] tw_addr(input logic [CNT_W-1:0] n);
    int unsigned p;
    int unsigned q;
    int unsigned r;
    p = 32'(n) % (4 * SEG);
    q = p / SEG;
    r = (p % SEG) / (SEG / 4);
    if (q != 3) return TW_W0;
    case (r)
      0:       return TW_W0;
      1:       return TW_W1;
      2:       return TW_W2;
      default: return TW_W3;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx;
  logic [5:0]       addr_q, addr_d;
  logic [DW-1:0]    mult_r_q, mult_r_d;
  logic [DW-1:0]    mult_i_q, mult_i_d;
  flags_t           flags1_q, flags1_d;
  flags_t           flags2;

  always_comb begin
    idx      = (in_valid_i && in_sof_i) ? '0 : cnt_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    mult_r_d = mult_r_q;
    mult_i_d = mult_i_q;
    flags1_d = '0;
    if (in_valid_i) begin
      cnt_d          = idx + CNT_W'(1);
      addr_d         = tw_addr(idx);
      mult_r_d       = in_r_i;
      mult_i_d       = in_i_i;
      flags1_d.valid = 1'b1;
      flags1_d.sof   = (idx == '0);
      flags1_d.last  = (idx == LAST_IDX);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      addr_q   <= TW_W0;
      mult_r_q <= '0;
      mult_i_q <= '0;
      flags1_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      mult_r_q <= mult_r_d;
      mult_i_q <= mult_i_d;
      flags1_q <= flags1_d;
    end
  end

  // Flags ride one more register so they line up with the multiplier product.
  delay_unit #(
    .WIDTH($bits(flags_t))
  ) u_flag_dly (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d_i    (flags1_q),
    .q_o    (flags2)
  );

  assign mult_addr_o = addr_q;
  assign mult_r_o    = mult_r_q;
  assign mult_i_o    = mult_i_q;
  assign out_valid_o = flags2.valid;
  assign out_sof_o   = flags2.sof;
  assign out_last_o  = flags2.last;

`ifdef FRAME_CHECK_EN
  logic seen_sof_q, seen_sof_d;
  logic frame_err_q, frame_err_d;

  // A sof away from index 0, or an unflagged index-0 sample before any sof, marks the stream bad.
  always_comb begin
    seen_sof_d  = seen_sof_q;
    frame_err_d = frame_err_q;
    if (in_valid_i) begin
      if (in_sof_i) begin
        seen_sof_d = 1'b1;
        if (cnt_q != '0) frame_err_d = 1'b1;
      end else if ((cnt_q == '0) && !seen_sof_q) begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      seen_sof_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      seen_sof_q  <= seen_sof_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err_o = frame_err_q;
`endif

endmodule

// File: tb/tb_twiddle_sequencer_fft.sv
// Bench for twiddle_sequencer_fft: random stream against a frame-index model,
// plus directed frame, bubble, resync, wrap and async-reset scenarios.
module tb_twiddle_sequencer_fft;

  localparam int DW   = 18;
  localparam int NFFT = 64;
  localparam int SEG  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_r = '0;
  logic [DW-1:0] in_i = '0;
  logic [5:0]    mult_addr;
  logic [DW-1:0] mult_r, mult_i;
  logic          out_valid, out_sof, out_last;
`ifdef FRAME_CHECK_EN
  logic          frame_err;
`endif

  twiddle_sequencer_fft dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .in_valid_i (in_valid),
    .in_sof_i   (in_sof),
    .in_r_i     (in_r),
    .in_i_i     (in_i),
    .mult_addr_o(mult_addr),
    .mult_r_o   (mult_r),
    .mult_i_o   (mult_i),
    .out_valid_o(out_valid),
    .out_sof_o  (out_sof),
`ifdef FRAME_CHECK_EN
    .frame_err_o(frame_err),
`endif
    .out_last_o (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame index per accepted sample, history of the last two clock edges.
  int            m_cnt;
  bit            m_seen;
  bit            exp_err;
  logic [DW-1:0] exp_r, exp_i;
  logic [5:0]    exp_addr;
  int            hist[$];
  int            cyc = 0;

  function automatic logic [5:0] ref_addr(input int n);
    int p;
    p = n % (4 * SEG);
    if (p / SEG != 3) return 6'd0;
    return 6'((p % SEG) / (SEG / 4));
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_seen = 0; exp_err = 0;
      exp_r = '0; exp_i = '0; exp_addr = '0;
      hist.delete(); hist.push_back(-1); hist.push_back(-1);
    end else begin
      int idx;
      idx = -1;
      if (in_valid) begin
        idx = in_sof ? 0 : m_cnt;
        if (in_sof && m_cnt != 0) exp_err = 1;
        if (!in_sof && m_cnt == 0 && !m_seen) exp_err = 1;
        if (in_sof) m_seen = 1;
        m_cnt = (idx + 1) % NFFT;
        exp_r = in_r; exp_i = in_i; exp_addr = ref_addr(idx);
      end
      hist.push_back(idx);
      void'(hist.pop_front());
    end
  end

  // Observation logs used by the directed scenarios.
  logic [5:0] addr_log[$];
  int         sof_pos[$];
  int         last_pos[$];
  int         sof_cyc[$];
  int         out_n = 0;

  task automatic clear_logs();
    addr_log.delete(); sof_pos.delete(); last_pos.delete(); sof_cyc.delete();
    out_n = 0;
  endtask

  always @(negedge clk) begin
    if (hist.size() == 2) begin
      chk("mult_addr", 32'(mult_addr), 32'(exp_addr));
      chk("mult_r", 32'(mult_r), 32'(exp_r));
      chk("mult_i", 32'(mult_i), 32'(exp_i));
      chk("out_valid", 32'(out_valid), 32'(hist[0] != -1));
      chk("out_sof", 32'(out_sof), 32'(hist[0] == 0));
      chk("out_last", 32'(out_last), 32'(hist[0] == NFFT - 1));
`ifdef FRAME_CHECK_EN
      chk("frame_err", 32'(frame_err), 32'(exp_err));
`endif
      if (rst_n) begin
        if (hist[1] != -1) addr_log.push_back(mult_addr);
        if (out_valid) begin
          if (out_sof) begin sof_pos.push_back(out_n); sof_cyc.push_back(cyc); end
          if (out_last) last_pos.push_back(out_n);
          out_n++;
        end
      end
    end
  end

  task automatic send(input bit v, input bit s);
    @(posedge clk); #1;
    in_valid = v; in_sof = s;
    in_r = DW'($urandom); in_i = DW'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_addr0"}, 32'(mult_addr), 32'd0);
    chk({tag, "_r0"}, 32'(mult_r), 32'd0);
    chk({tag, "_i0"}, 32'(mult_i), 32'd0);
    chk({tag, "_valid0"}, 32'(out_valid), 32'd0);
    chk({tag, "_sof0"}, 32'(out_sof), 32'd0);
    chk({tag, "_last0"}, 32'(out_last), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int sof_drive_cyc;
    int pin_n[12] = '{0, 25, 26, 27, 28, 29, 30, 31, 32, 57, 58, 63};
    int pin_a[12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 3};

    // 1: reset held with random inputs
    repeat (6) send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; in_sof = 1'b0;

    // 2: full frame
    do_reset();
    clear_logs();
    send(1'b1, 1'b1);
    sof_drive_cyc = cyc;
    repeat (63) send(1'b1, 1'b0);
    idle(4);
    chk("frame_addr_count", 32'(addr_log.size()), 32'd64);
    if (addr_log.size() == 64) begin
      for (int k = 0; k < 12; k++) chk($sformatf("frame_addr_n%0d", pin_n[k]), 32'(addr_log[pin_n[k]]), 32'(pin_a[k]));
    end
    chk("frame_sof_count", 32'(sof_pos.size()), 32'd1);
    if (sof_pos.size() == 1) chk("frame_sof_pos", 32'(sof_pos[0]), 32'd0);
    if (sof_cyc.size() == 1) chk("frame_sof_latency", 32'(sof_cyc[0] - sof_drive_cyc), 32'd2);
    chk("frame_last_count", 32'(last_pos.size()), 32'd1);
    if (last_pos.size() == 1) chk("frame_last_pos", 32'(last_pos[0]), 32'd63);
`ifdef FRAME_CHECK_EN
    chk("frame_no_err", 32'(frame_err), 32'd0);
`endif

    // 3: bubbles around the first nonzero twiddle
    do_reset();
    clear_logs();
    send(1'b1, 1'b1);
    repeat (26) send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    idle(4);
    chk("bubble_count", 32'(out_n), 32'd29);
    if (addr_log.size() == 29) begin
      chk("bubble_addr26", 32'(addr_log[26]), 32'd1);
      chk("bubble_addr27", 32'(addr_log[27]), 32'd1);
      chk("bubble_addr28", 32'(addr_log[28]), 32'd2);
    end else chk("bubble_addr_count", 32'(addr_log.size()), 32'd29);

    // 4: mid-frame resync at index 17
    do_reset();
    clear_logs();
    send(1'b1, 1'b1);
    repeat (16) send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    repeat (27) send(1'b1, 1'b0);
    idle(4);
    if (addr_log.size() == 45) begin
      chk("resync_addr17", 32'(addr_log[17]), 32'd0);
      chk("resync_addr43", 32'(addr_log[43]), 32'd1);
    end else chk("resync_addr_count", 32'(addr_log.size()), 32'd45);
    chk("resync_sof_count", 32'(sof_pos.size()), 32'd2);
    if (sof_pos.size() == 2) chk("resync_sof_pos", 32'(sof_pos[1]), 32'd17);
`ifdef FRAME_CHECK_EN
    chk("resync_err", 32'(frame_err), 32'd1);
    idle(3);
    chk("resync_err_sticky", 32'(frame_err), 32'd1);
`endif

    // 5: wrap across two frame boundaries with a single sof
    do_reset();
    clear_logs();
    send(1'b1, 1'b1);
    repeat (129) send(1'b1, 1'b0);
    idle(4);
    chk("wrap_sof_count", 32'(sof_pos.size()), 32'd3);
    if (sof_pos.size() == 3) begin
      chk("wrap_sof1", 32'(sof_pos[1]), 32'd64);
      chk("wrap_sof2", 32'(sof_pos[2]), 32'd128);
    end
    chk("wrap_last_count", 32'(last_pos.size()), 32'd2);
    if (last_pos.size() == 2) begin
      chk("wrap_last0", 32'(last_pos[0]), 32'd63);
      chk("wrap_last1", 32'(last_pos[1]), 32'd127);
    end
`ifdef FRAME_CHECK_EN
    chk("wrap_no_err", 32'(frame_err), 32'd0);
`endif

    // 6: async reset between edges
    do_reset();
    send(1'b1, 1'b1);
    repeat (27) send(1'b1, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async");
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    clear_logs();
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    idle(4);
    chk("postrst_sof_count", 32'(sof_pos.size()), 32'd1);
    if (sof_pos.size() == 1) chk("postrst_sof_pos", 32'(sof_pos[0]), 32'd0);
`ifdef FRAME_CHECK_EN
    chk("postrst_err", 32'(frame_err), 32'd1);
`endif

    // 7: random stream with an async reset pulse in the middle
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) begin
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      send(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
